counter_compare_monitor: RTL and testbench

Synthesizable, parametrised golden-versus-netlist comparator for counter-style test designs. It takes NUM_CH channels of CNT_W-bit golden and implementation values with a per-channel sample strobe and counts checks per channel. It records mismatches: a saturating total, sticky per-channel flags, and a first-failure snapshot. When every channel has completed its programmed number of checks it reports done and pass. It sits beside the multi-clock counter test designs on their common synchronised clock and replaces per-channel hand-written compare logic.

---
 rtl/counter_compare_monitor_pkg.sv | 22 ++
 rtl/counter_compare_monitor_if.sv | 43 ++++
 rtl/counter_compare_monitor_channel.sv | 57 +++++
 rtl/counter_compare_monitor.sv | 131 +++++++++++++
 tb/tb_counter_compare_monitor.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_compare_monitor_pkg.sv
// Shared types and helpers for the golden-versus-implementation counter comparator.
package counter_compare_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ccm_state_e;

  localparam int MAX_CH = 32;

  // Width of a channel index; never below one bit so a single channel still has a port.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_CH-1:0] v);
    logic [5:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      acc = acc + {5'd0, v[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/counter_compare_monitor_if.sv
// Control, sample and result bundle of the comparator; master drives samples, slave is the monitor.
interface counter_compare_monitor_if #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int CHK_W  = 16,
  parameter int ERR_W  = 16
) ();
  import counter_compare_pkg::*;

  localparam int IDX_W = ch_idx_w(NUM_CH);

  // Handshake: sample_vld[i] qualifies golden/dut slice i for exactly the cycle it is high; there is no back-pressure.
  logic                    start;
  logic [CHK_W-1:0]        num_checks;
  logic [NUM_CH-1:0]       sample_vld;
  logic [NUM_CH*CNT_W-1:0] golden_cnt;
  logic [NUM_CH*CNT_W-1:0] dut_cnt;

  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [ERR_W-1:0]        mismatch_cnt;
  logic [NUM_CH-1:0]       ch_fail;
  logic [NUM_CH-1:0]       ch_done;
  logic                    first_err_vld;
  logic [IDX_W-1:0]        first_err_ch;
  logic [CNT_W-1:0]        first_err_golden;
  logic [CNT_W-1:0]        first_err_dut;
  ccm_state_e              fsm_state;

  modport master (
    output start, num_checks, sample_vld, golden_cnt, dut_cnt,
    input  busy, done, pass, mismatch_cnt, ch_fail, ch_done,
           first_err_vld, first_err_ch, first_err_golden, first_err_dut, fsm_state
  );

  modport slave (
    input  start, num_checks, sample_vld, golden_cnt, dut_cnt,
    output busy, done, pass, mismatch_cnt, ch_fail, ch_done,
           first_err_vld, first_err_ch, first_err_golden, first_err_dut, fsm_state
  );

endinterface

// File: rtl/counter_compare_monitor_channel.sv
// One compared channel: check counter, sticky done/fail flags and a combinational mismatch pulse.
module compare_channel #(
  parameter int CNT_W = 8,
  parameter int CHK_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic             sample_vld_i,
  input  logic [CNT_W-1:0] golden_i,
  input  logic [CNT_W-1:0] dut_i,
  input  logic [CHK_W-1:0] num_checks_i,
  output logic             ch_done_o,
  output logic             ch_fail_o,
  output logic             mismatch_o
);

  logic [CHK_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             accept;

  // The count test also blocks acceptance on the first cycle of a zero-check run.
  always_comb begin
    accept     = run_i & sample_vld_i & ~done_q & (count_q != num_checks_i);
    mismatch_o = accept & (golden_i != dut_i);
    count_d    = count_q;
    done_d     = done_q;
    fail_d     = fail_q;
    if (clear_i) begin
      count_d = '0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
    end else if (run_i) begin
      if (accept) count_d = count_q + CHK_W'(1);
      done_d = done_q | (count_d == num_checks_i);
      fail_d = fail_q | mismatch_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign ch_done_o = done_q;
  assign ch_fail_o = fail_q;

endmodule

// File: rtl/counter_compare_monitor.sv
// Run FSM, saturating mismatch total and first-failure snapshot over NUM_CH compare channels.
module counter_compare_monitor
  import counter_compare_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int CHK_W  = 16,
  parameter int ERR_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  counter_compare_monitor_if.slave bus
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  ccm_state_e        state_q, state_d;
  logic              clear, run;
  logic [CHK_W-1:0]  num_q, num_d;
  logic [ERR_W-1:0]  mism_q, mism_d;
  logic              pass_q, pass_d;
  logic              fvld_q, fvld_d;
  logic [IDX_W-1:0]  fch_q, fch_d;
  logic [CNT_W-1:0]  fgold_q, fgold_d;
  logic [CNT_W-1:0]  fdut_q, fdut_d;
  logic [NUM_CH-1:0] mism_w, ch_done_w, ch_fail_w;
  logic [MAX_CH-1:0] mism_ext;
  logic [ERR_W+6:0]  sum_w;

  assign run = (state_q == RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    compare_channel #(.CNT_W(CNT_W), .CHK_W(CHK_W)) u_ch (
      .clk_i        (clk),
      .rst_i        (reset),
      .clear_i      (clear),
      .run_i        (run),
      .sample_vld_i (bus.sample_vld[i]),
      .golden_i     (bus.golden_cnt[i*CNT_W +: CNT_W]),
      .dut_i        (bus.dut_cnt[i*CNT_W +: CNT_W]),
      .num_checks_i (num_q),
      .ch_done_o    (ch_done_w[i]),
      .ch_fail_o    (ch_fail_w[i]),
      .mismatch_o   (mism_w[i])
    );
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    num_d   = num_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = RUN;
        clear   = 1'b1;
        num_d   = bus.num_checks;
      end
      RUN: if (&ch_done_w) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Sum is wide enough for an all-ones total plus 32 simultaneous mismatches.
  always_comb begin
    mism_ext              = '0;
    mism_ext[NUM_CH-1:0]  = mism_w;
    sum_w = {7'd0, mism_q} + {{(ERR_W+1){1'b0}}, popcount(mism_ext)};
    if (clear) mism_d = '0;
    else if (sum_w > {7'd0, {ERR_W{1'b1}}}) mism_d = '1;
    else mism_d = sum_w[ERR_W-1:0];
    pass_d = (state_d == DONE) && (mism_d == '0);
  end

  // Descending scan leaves the lowest mismatching channel in the snapshot.
  always_comb begin
    fvld_d  = fvld_q;
    fch_d   = fch_q;
    fgold_d = fgold_q;
    fdut_d  = fdut_q;
    if (clear) begin
      fvld_d  = 1'b0;
      fch_d   = '0;
      fgold_d = '0;
      fdut_d  = '0;
    end else if (!fvld_q) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (mism_w[i]) begin
          fvld_d  = 1'b1;
          fch_d   = IDX_W'(i);
          fgold_d = bus.golden_cnt[i*CNT_W +: CNT_W];
          fdut_d  = bus.dut_cnt[i*CNT_W +: CNT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      mism_q  <= '0;
      pass_q  <= 1'b0;
      fvld_q  <= 1'b0;
      fch_q   <= '0;
      fgold_q <= '0;
      fdut_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      mism_q  <= mism_d;
      pass_q  <= pass_d;
      fvld_q  <= fvld_d;
      fch_q   <= fch_d;
      fgold_q <= fgold_d;
      fdut_q  <= fdut_d;
    end
  end

  assign bus.busy             = (state_q == RUN);
  assign bus.done             = (state_q == DONE);
  assign bus.pass             = pass_q;
  assign bus.mismatch_cnt     = mism_q;
  assign bus.ch_fail          = ch_fail_w;
  assign bus.ch_done          = ch_done_w;
  assign bus.first_err_vld    = fvld_q;
  assign bus.first_err_ch     = fch_q;
  assign bus.first_err_golden = fgold_q;
  assign bus.first_err_dut    = fdut_q;
  assign bus.fsm_state        = state_q;

endmodule

// File: tb/tb_counter_compare_monitor.sv
// Directed bench for counter_compare_monitor: a 16-channel instance and a 4-channel, 4-bit-total instance.
module tb_counter_compare_monitor;
  import counter_compare_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  counter_compare_monitor_if #(.NUM_CH(16), .CNT_W(8), .CHK_W(16), .ERR_W(16)) bus ();
  counter_compare_monitor_if #(.NUM_CH(4),  .CNT_W(8), .CHK_W(16), .ERR_W(4))  sbus ();

  counter_compare_monitor #(.NUM_CH(16), .CNT_W(8), .CHK_W(16), .ERR_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  counter_compare_monitor #(.NUM_CH(4), .CNT_W(8), .CHK_W(16), .ERR_W(4)) u_sat (
    .clk(clk), .reset(reset), .bus(sbus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic vld, input logic [7:0] g, input logic [7:0] d);
    bus.sample_vld[i]        = vld;
    bus.golden_cnt[i*8 +: 8] = g;
    bus.dut_cnt[i*8 +: 8]    = d;
  endtask

  task automatic clear_strobes();
    bus.sample_vld  = '0;
    sbus.sample_vld = '0;
  endtask

  task automatic do_start(input logic [15:0] n);
    bus.num_checks = n;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_state"},  32'(bus.fsm_state), 32'(IDLE));
    check_eq({tag, "_busy"},   32'(bus.busy), 0);
    check_eq({tag, "_done"},   32'(bus.done), 0);
    check_eq({tag, "_pass"},   32'(bus.pass), 0);
    check_eq({tag, "_mism"},   32'(bus.mismatch_cnt), 0);
    check_eq({tag, "_fail"},   32'(bus.ch_fail), 0);
    check_eq({tag, "_chdone"}, 32'(bus.ch_done), 0);
    check_eq({tag, "_fvld"},   32'(bus.first_err_vld), 0);
    check_eq({tag, "_fch"},    32'(bus.first_err_ch), 0);
    check_eq({tag, "_fgold"},  32'(bus.first_err_golden), 0);
    check_eq({tag, "_fdut"},   32'(bus.first_err_dut), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.num_checks  = '0;
    bus.sample_vld  = '0;
    bus.golden_cnt  = '0;
    bus.dut_cnt     = '0;
    sbus.start      = 1'b0;
    sbus.num_checks = '0;
    sbus.sample_vld = '0;
    sbus.golden_cnt = '0;
    sbus.dut_cnt    = '0;
    tick();
    tick();
    check_reset("rst");
    check_eq("rst_sat_mism", 32'(sbus.mismatch_cnt), 0);
    reset = 1'b0;
    tick();

    // All-match run with strobe periods 1..4 cycles.
    do_start(16'd200);
    check_eq("am_busy", 32'(bus.busy), 1);
    for (int c = 0; c < 797; c++) begin
      for (int i = 0; i < 16; i++)
        set_ch(i, (c % ((i % 4) + 1)) == 0, 8'(c + i), 8'(c + i));
      tick();
      if (c == 199) check_eq("am_chdone_p1", 32'(bus.ch_done), 'h1111);
    end
    check_eq("am_chdone_all", 32'(bus.ch_done), 'hffff);
    check_eq("am_done_pre", 32'(bus.done), 0);
    clear_strobes();
    tick();
    check_eq("am_done", 32'(bus.done), 1);
    check_eq("am_pass", 32'(bus.pass), 1);
    check_eq("am_mism", 32'(bus.mismatch_cnt), 0);
    check_eq("am_fail", 32'(bus.ch_fail), 0);
    check_eq("am_busy_end", 32'(bus.busy), 0);

    // Single fault on channel 5 at its 37th check.
    do_start(16'd50);
    for (int c = 0; c < 50; c++) begin
      for (int i = 0; i < 16; i++)
        set_ch(i, 1'b1, 8'(c), (i == 5 && c == 36) ? 8'd37 : 8'(c));
      tick();
      if (c == 35) check_eq("sf_fvld_before", 32'(bus.first_err_vld), 0);
      if (c == 36) check_eq("sf_fvld_after", 32'(bus.first_err_vld), 1);
    end
    clear_strobes();
    tick();
    check_eq("sf_done",  32'(bus.done), 1);
    check_eq("sf_pass",  32'(bus.pass), 0);
    check_eq("sf_fail",  32'(bus.ch_fail), 'h20);
    check_eq("sf_mism",  32'(bus.mismatch_cnt), 1);
    check_eq("sf_fch",   32'(bus.first_err_ch), 5);
    check_eq("sf_fgold", 32'(bus.first_err_golden), 36);
    check_eq("sf_fdut",  32'(bus.first_err_dut), 37);

    // Start from DONE clears results; simultaneous faults; start in RUN ignored.
    do_start(16'd10);
    check_eq("sm_clr_mism", 32'(bus.mismatch_cnt), 0);
    check_eq("sm_clr_fail", 32'(bus.ch_fail), 0);
    check_eq("sm_clr_fvld", 32'(bus.first_err_vld), 0);
    check_eq("sm_clr_done", 32'(bus.done), 0);
    check_eq("sm_clr_pass", 32'(bus.pass), 0);
    check_eq("sm_clr_busy", 32'(bus.busy), 1);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 16; i++) begin
        if ((c == 2 && (i == 3 || i == 9 || i == 12)) || (c == 5 && i == 1))
          set_ch(i, 1'b1, 8'(c), 8'(c ^ 1));
        else
          set_ch(i, 1'b1, 8'(c), 8'(c));
      end
      if (c == 4) begin
        bus.start      = 1'b1;
        bus.num_checks = 16'd0;
      end
      tick();
      bus.start = 1'b0;
      if (c == 2) begin
        check_eq("sm_mism3", 32'(bus.mismatch_cnt), 3);
        check_eq("sm_fch3",  32'(bus.first_err_ch), 3);
        check_eq("sm_fail3", 32'(bus.ch_fail), 'h1208);
      end
      if (c == 4) check_eq("sm_run_start_ignored", 32'(bus.mismatch_cnt), 3);
      if (c == 5) begin
        check_eq("sm_mism4",  32'(bus.mismatch_cnt), 4);
        check_eq("sm_fail4",  32'(bus.ch_fail), 'h120a);
        check_eq("sm_fch_hold", 32'(bus.first_err_ch), 3);
        check_eq("sm_fgold",  32'(bus.first_err_golden), 2);
        check_eq("sm_fdut",   32'(bus.first_err_dut), 3);
      end
    end
    clear_strobes();
    tick();
    check_eq("sm_done", 32'(bus.done), 1);
    check_eq("sm_pass", 32'(bus.pass), 0);

    // Strobes after a channel's ch_done, and in DONE, are ignored.
    do_start(16'd3);
    for (int c = 0; c < 5; c++) begin
      set_ch(0, 1'b1, 8'(c), (c >= 3) ? 8'(c + 1) : 8'(c));
      for (int i = 1; i < 16; i++) set_ch(i, (c % 2) == 0, 8'(c), 8'(c));
      tick();
      if (c == 2) check_eq("ig_chdone0", 32'(bus.ch_done), 'h0001);
    end
    check_eq("ig_chdone_all", 32'(bus.ch_done), 'hffff);
    check_eq("ig_mism", 32'(bus.mismatch_cnt), 0);
    for (int i = 0; i < 16; i++) set_ch(i, 1'b1, 8'h10, 8'h20);
    tick();
    check_eq("ig_done", 32'(bus.done), 1);
    tick();
    tick();
    check_eq("ig_done_mism", 32'(bus.mismatch_cnt), 0);
    check_eq("ig_done_fail", 32'(bus.ch_fail), 0);
    check_eq("ig_done_pass", 32'(bus.pass), 1);

    // num_checks == 0 with mismatching strobes held high.
    do_start(16'd0);
    check_eq("z_busy", 32'(bus.busy), 1);
    check_eq("z_chdone0", 32'(bus.ch_done), 0);
    tick();
    check_eq("z_chdone1", 32'(bus.ch_done), 'hffff);
    check_eq("z_done1", 32'(bus.done), 0);
    tick();
    check_eq("z_done2", 32'(bus.done), 1);
    check_eq("z_pass2", 32'(bus.pass), 1);
    check_eq("z_mism2", 32'(bus.mismatch_cnt), 0);

    // Asynchronous reset in the middle of a run, then a fresh run.
    clear_strobes();
    do_start(16'd100);
    for (int c = 0; c < 50; c++) begin
      for (int i = 0; i < 16; i++)
        set_ch(i, 1'b1, 8'(c), (i == 2 && c == 10) ? 8'(c + 1) : 8'(c));
      tick();
    end
    check_eq("mr_mism_pre", 32'(bus.mismatch_cnt), 1);
    check_eq("mr_fch_pre",  32'(bus.first_err_ch), 2);
    reset = 1'b1;
    #1;
    check_reset("mr");
    #1;
    reset = 1'b0;
    tick();
    check_eq("mr_idle_busy", 32'(bus.busy), 0);
    check_eq("mr_idle_mism", 32'(bus.mismatch_cnt), 0);
    do_start(16'd2);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) set_ch(i, 1'b1, 8'(c), 8'(c));
      tick();
    end
    check_eq("mr_chdone", 32'(bus.ch_done), 'hffff);
    clear_strobes();
    tick();
    check_eq("mr_done", 32'(bus.done), 1);
    check_eq("mr_pass", 32'(bus.pass), 1);

    // Saturation of a 4-bit total with four channels always mismatching.
    sbus.num_checks = 16'd10;
    sbus.start      = 1'b1;
    tick();
    sbus.start      = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sbus.sample_vld = 4'hf;
      sbus.golden_cnt = {4{8'(c)}};
      sbus.dut_cnt    = {4{8'(c + 1)}};
      tick();
      if (c == 0) check_eq("sat_e1", 32'(sbus.mismatch_cnt), 4);
      if (c == 2) check_eq("sat_e3", 32'(sbus.mismatch_cnt), 12);
      if (c == 3) check_eq("sat_e4", 32'(sbus.mismatch_cnt), 15);
      if (c == 9) check_eq("sat_e10", 32'(sbus.mismatch_cnt), 15);
    end
    clear_strobes();
    tick();
    check_eq("sat_done", 32'(sbus.done), 1);
    check_eq("sat_pass", 32'(sbus.pass), 0);
    check_eq("sat_fail", 32'(sbus.ch_fail), 'hf);
    tick();
    check_eq("sat_hold", 32'(sbus.mismatch_cnt), 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
